// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and opcode helpers for the iterative RV32M
// multiply/divide unit.
//   mdu_op_e    - RISC-V funct3 encoding of the eight M-extension operations
//   mdu_state_e - controller states
//   is_div / is_rem / is_signed_a / is_signed_b / selects_high - opcode decode
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_div(mdu_op_e op);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

  function automatic logic is_rem(mdu_op_e op);
    return (op inside {OP_REM, OP_REMU});
  endfunction

  function automatic logic is_signed_a(mdu_op_e op);
    return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  endfunction

  function automatic logic is_signed_b(mdu_op_e op);
    return (op inside {OP_MULH, OP_DIV, OP_REM});
  endfunction

  function automatic logic selects_high(mdu_op_e op);
    return (op inside {OP_MULH, OP_MULHSU, OP_MULHU});
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response bundle of the multiply/divide unit.
//   in_valid/in_ready  - request handshake (op, a, b)
//   out_valid/out_ready- response handshake (result)
//   flush              - abort the operation in flight
//   busy               - unit is not idle
// Modports: master (control unit side), slave (MDU side).
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  mdu_op_e         op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_operand_prep.sv
// mdu_operand_prep: combinational operand conditioning for the MDU.
//   i_op, i_a, i_b      - requested operation and raw operands
//   o_abs_a, o_abs_b    - unsigned magnitudes (|MIN| fits as unsigned)
//   o_sign_a, o_sign_b  - operand sign flags (0 for unsigned operands)
//   o_fast              - result known without iterating
//   o_fast_result       - that result (div-by-zero or signed overflow)
module mdu_operand_prep
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mdu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_abs_a,
  output logic [XLEN-1:0] o_abs_b,
  output logic            o_sign_a,
  output logic            o_sign_b,
  output logic            o_fast,
  output logic [XLEN-1:0] o_fast_result
);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic w_b_zero;
  logic w_ovf;

  assign o_sign_a = is_signed_a(i_op) & i_a[XLEN-1];
  assign o_sign_b = is_signed_b(i_op) & i_b[XLEN-1];
  assign o_abs_a  = o_sign_a ? ('0 - i_a) : i_a;
  assign o_abs_b  = o_sign_b ? ('0 - i_b) : i_b;

  assign w_b_zero = (i_b == '0);
  // Only DIV/REM can overflow: MIN / -1 does not fit in XLEN signed bits.
  assign w_ovf    = is_div(i_op) & is_signed_b(i_op) & (i_a == MIN_VAL) & (i_b == '1);
  assign o_fast   = is_div(i_op) & (w_b_zero | w_ovf);

  always_comb begin
    if (w_b_zero) o_fast_result = is_rem(i_op) ? i_a : '1;
    else          o_fast_result = is_rem(i_op) ? '0  : MIN_VAL;
  end
endmodule

// File: rtl/iterative_mdu.sv
// iterative_mdu: multi-cycle RV32M multiply/divide unit.
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - mdu_if.slave: request (in_valid/in_ready/op/a/b), flush,
//             response (out_valid/out_ready/result) and busy
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per
// cycle for XLEN cycles, followed by a single sign-fix/select cycle.
module iterative_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  reset_n,
  mdu_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  mdu_state_e        r_state;
  mdu_state_e        w_state_nxt;
  mdu_op_e           r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvs;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_result;

  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN-1:0]   w_fast_result;
  logic              w_sign_a;
  logic              w_sign_b;
  logic              w_fast;
  logic              w_accept;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_result;

  mdu_operand_prep #(.XLEN(XLEN)) u_prep (
    .i_op          (bus.op),
    .i_a           (bus.a),
    .i_b           (bus.b),
    .o_abs_a       (w_abs_a),
    .o_abs_b       (w_abs_b),
    .o_sign_a      (w_sign_a),
    .o_sign_b      (w_sign_b),
    .o_fast        (w_fast),
    .o_fast_result (w_fast_result)
  );

  // A request coincident with flush is dropped.
  assign w_accept = (r_state == IDLE) & bus.in_valid & ~bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = w_fast ? DONE : CALC;
      CALC:    if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush) w_state_nxt = IDLE;
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
    bus.busy      = (r_state != IDLE);
    bus.result    = r_result;
  end

  // Multiplier sits in the low half of the accumulator and is consumed LSB
  // first; partial products enter the high half with their carry.
  assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_mcand : '0)};

  // The remainder stays below the divisor, so the shifted value fits XLEN+1
  // bits and the committed difference fits XLEN bits.
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_dvs;

  assign w_prod    = r_neg_res ? ('0 - r_acc) : r_acc;
  assign w_quo_fix = r_neg_res ? ('0 - r_quo) : r_quo;
  assign w_rem_fix = r_neg_rem ? ('0 - r_rem) : r_rem;

  always_comb begin
    if (is_div(r_op))          w_fix_result = is_rem(r_op) ? w_rem_fix : w_quo_fix;
    else if (selects_high(r_op)) w_fix_result = w_prod[2*XLEN-1:XLEN];
    else                       w_fix_result = w_prod[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= OP_MUL;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= bus.op;
        r_cnt     <= CNT_W'(XLEN);
        r_neg_res <= w_sign_a ^ w_sign_b;
        r_neg_rem <= w_sign_a;
        r_acc     <= {{XLEN{1'b0}}, w_abs_b};
        r_mcand   <= w_abs_a;
        r_rem     <= '0;
        r_quo     <= w_abs_a;
        r_dvs     <= w_abs_b;
        if (w_fast) r_result <= w_fast_result;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (is_div(r_op)) begin
          r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
        end else begin
          r_acc <= {w_sum, r_acc[XLEN-1:1]};
        end
      end else if ((r_state == FIX) && !bus.flush) begin
        r_result <= w_fix_result;
      end
    end
  end
endmodule

// File: tb/tb_iterative_mdu.sv
// tb_iterative_mdu: self-checking bench for iterative_mdu (XLEN=32).
// Directed vectors, backpressure, flush, async reset and randomized
// operations checked against a plain-arithmetic reference model.
module tb_iterative_mdu;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mdu_if #(.XLEN(XLEN)) bus_if ();

  iterative_mdu #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(mdu_op_e op, logic [31:0] a, logic [31:0] b);
    int          sa;
    int          sb;
    longint      la;
    longint      lb;
    longint      ub;
    longint      ua;
    logic [63:0] p;
    logic        ovf;
    sa  = a;
    sb  = b;
    la  = sa;
    lb  = sb;
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      OP_MUL:    begin p = la * lb; return p[31:0];  end
      OP_MULH:   begin p = la * lb; return p[63:32]; end
      OP_MULHSU: begin p = la * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_REM:    begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'(sa % sb);
      end
      OP_DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      default:   begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic is_fast(mdu_op_e op, logic [31:0] a, logic [31:0] b);
    logic divop;
    logic sdiv;
    divop = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    sdiv  = (op == OP_DIV) || (op == OP_REM);
    return divop && ((b == 0) || (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int w;
    w = 0;
    while (!bus_if.in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) chk({tag, "_rdy_timeout"}, 32'(bus_if.in_ready), 32'h1);
    bus_if.op       = op;
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  // Counts rising edges from the accepting edge (inclusive) to the edge
  // after which out_valid is first seen high.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus_if.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int lat;
    int exp_lat;
    exp_lat = is_fast(op, a, b) ? 1 : XLEN + 2;
    issue(op, a, b, tag);
    wait_valid(lat);
    chk({tag, "_res"}, bus_if.result, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    chk({tag, "_idle"}, 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'h4);
  endtask

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          lat;
    int          bad;
    logic [31:0] held;
    mdu_op_e     rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus_if.in_valid  = 1'b0;
    bus_if.op        = OP_MUL;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.flush     = 1'b0;
    bus_if.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'h4);
    chk("rst_result", bus_if.result, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ctrl", 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'h4);

    vecs.push_back('{OP_MUL,    32'd7,          32'd6,          32'd42,         "mul"});
    vecs.push_back('{OP_MULH,   32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  "mulh"});
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  "mulhu"});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mulhsu"});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div"});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem"});
    vecs.push_back('{OP_DIVU,   32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF,  "divu"});
    vecs.push_back('{OP_REMU,   32'd10,         32'd3,          32'd1,          "remu"});
    vecs.push_back('{OP_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  "div0"});
    vecs.push_back('{OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  "divu0"});
    vecs.push_back('{OP_REM,    32'd5,          32'd0,          32'd5,          "rem0"});
    vecs.push_back('{OP_REMU,   32'd5,          32'd0,          32'd5,          "remu0"});
    vecs.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"});
    vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          "rem_ovf"});
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].tag);

    // Backpressure: result held, new request ignored while DONE.
    issue(OP_DIVU, 32'd100, 32'd7, "bp");
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'(XLEN + 2));
    bus_if.op       = OP_MUL;
    bus_if.a        = 32'd9;
    bus_if.b        = 32'd9;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_res", bus_if.result, 32'd14);
      chk("bp_ctrl", 32'({bus_if.out_valid, bus_if.in_ready}), 32'h2);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    chk("bp_idle", 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'h4);
    @(posedge clk); #1;
    chk("bp_no_accept", 32'(bus_if.busy), 32'h0);

    // Flush coincident with a request drops it.
    bus_if.op       = OP_MUL;
    bus_if.a        = 32'd2;
    bus_if.b        = 32'd2;
    bus_if.in_valid = 1'b1;
    bus_if.flush    = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.flush    = 1'b0;
    chk("flush_accept", 32'({bus_if.in_ready, bus_if.busy}), 32'h2);

    // Flush during CALC of a DIV.
    held = bus_if.result;
    issue(OP_DIV, 32'd1000, 32'd7, "flush");
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("flush_busy_before", 32'(bus_if.busy), 32'h1);
    bus_if.flush = 1'b1;
    @(posedge clk); #1;
    bus_if.flush = 1'b0;
    chk("flush_idle", 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'h4);
    chk("flush_result_held", bus_if.result, held);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid || bus_if.busy) bad++;
    end
    chk("flush_no_valid", 32'(bad), 32'h0);
    run_op(OP_MUL, 32'd3, 32'd4, 32'd12, "flush_mul");

    // Asynchronous reset in the middle of CALC.
    issue(OP_MUL, 32'd5, 32'd6, "arst");
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ctrl", 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'h4);
    chk("arst_result", bus_if.result, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_release", 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'h4);
    run_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, ref_mdu(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), "arst_mul");

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = mdu_op_e'(3'($urandom_range(0, 7)));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 100));
        4: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rop, ra, rb, ref_mdu(rop, ra, rb), $sformatf("rnd%0d_op%0d", i, int'(rop)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
